// File: rtl/shiftadd_mult_serial_if.sv
// rtl/shiftadd_mult_serial_if.sv - operand/result bundle for the serial shift-add multiplier
//
// Purpose: groups the multiplier's request and response signals so the
// requester and the multiplier share one connection.
// Signals:
//   start_i   requester -> mult  start request, sampled only while idle
//   a_i       requester -> mult  W-bit multiplicand
//   b_i       requester -> mult  W-bit multiplier
//   busy_o    mult -> requester  high while iterating
//   result_o  mult -> requester  registered 2W-bit product
//   valid_o   mult -> requester  one-cycle pulse when result_o updates
// Modports: master (requester side), slave (multiplier side).

interface shiftadd_mult_serial_if #(
  parameter int W = 32
);
  logic           start_i;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           busy_o;
  logic [2*W-1:0] result_o;
  logic           valid_o;

  modport master (
    output start_i,
    output a_i,
    output b_i,
    input  busy_o,
    input  result_o,
    input  valid_o
  );

  modport slave (
    input  start_i,
    input  a_i,
    input  b_i,
    output busy_o,
    output result_o,
    output valid_o
  );
endinterface

// File: rtl/shiftadd_mult_serial.sv
// rtl/shiftadd_mult_serial.sv - radix-2 serial shift-add unsigned multiplier, W cycles per product
//
// Purpose: computes the exact 2W-bit unsigned product a*b, one multiplier bit
// per clock, with fixed data-independent latency (W cycles start-to-valid,
// initiation interval W+2).
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  synchronous active-low reset
//   bus     shiftadd_mult_serial_if slave modport
//           (start_i, a_i, b_i in; busy_o, result_o, valid_o out)

module shiftadd_mult_serial #(
  parameter int W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  shiftadd_mult_serial_if.slave  bus
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [2*W-1:0]   r_mcand;
  logic [W-1:0]     r_mplier;
  logic [2*W-1:0]   r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_result;
  logic             r_valid;

  logic             w_accept;
  logic             w_last;
  logic [2*W-1:0]   w_acc_sum;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_accept     = 1'b1;
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_LAST) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Accumulator including the current iteration's partial product, so the
  // final iteration can publish the complete sum in the same edge.
  always_comb begin
    w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  // Datapath
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_mcand  <= {{W{1'b0}}, bus.a_i};
        r_mplier <= bus.b_i;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_CALC) begin
        r_acc    <= w_acc_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          r_result <= w_acc_sum;
          r_valid  <= 1'b1;
        end
      end
    end
  end

  assign bus.busy_o   = (r_state == S_CALC);
  assign bus.result_o = r_result;
  assign bus.valid_o  = r_valid;

endmodule

// File: tb/tb_shiftadd_mult_serial.sv
// tb/tb_shiftadd_mult_serial.sv - directed self-checking bench for shiftadd_mult_serial

module tb_shiftadd_mult_serial;

  localparam int W = 32;
  localparam logic [63:0] RED_M = 64'h7FFFFFFF;

  logic clk_i;
  logic rst_ni;

  shiftadd_mult_serial_if #(.W(W)) bus ();

  shiftadd_mult_serial #(.W(W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One operation from a single-cycle start pulse; checks latency, busy
  // length, product, and the single-cycle valid pulse.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, output logic [63:0] res);
    int lat;
    int busy_cnt;
    @(negedge clk_i);
    bus.a_i = a;
    bus.b_i = b;
    bus.start_i = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!bus.valid_o && lat < 100) begin
      if (bus.busy_o) busy_cnt++;
      @(negedge clk_i);
      lat++;
    end
    res = bus.result_o;
    chk({name, " latency"}, 64'(lat), 64'(W));
    chk({name, " busy cycles"}, 64'(busy_cnt), 64'(W));
    chk({name, " product"}, bus.result_o, exp);
    chk({name, " busy low at valid"}, 64'(bus.busy_o), 64'd0);
    @(negedge clk_i);
    chk({name, " valid one cycle"}, 64'(bus.valid_o), 64'd0);
    chk({name, " result held"}, bus.result_o, exp);
  endtask

  initial begin
    vec_t vecs[8];
    logic [63:0] res;
    int vcnt;
    int vlat;
    logic [63:0] vres;
    logic b33;
    logic b34;
    logic [63:0] r34;

    vecs[0] = '{32'd3,         32'd5,         64'h0F};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE00000001};
    vecs[2] = '{32'd0,         32'h12345678,  64'h0};
    vecs[3] = '{32'h80000000,  32'd2,         64'h100000000};
    vecs[4] = '{32'h7FFFFFFF,  32'h12345,     64'h91A27FFEDCBB};
    vecs[5] = '{32'd1,         32'hFFFFFFFF,  64'hFFFFFFFF};
    vecs[6] = '{32'h0000FFFF,  32'h00010000,  64'hFFFF0000};
    vecs[7] = '{32'h12345678,  32'd0,         64'h0};

    n_pass = 0;
    n_total = 0;

    // Reset with start asserted and random operands
    rst_ni = 1'b0;
    bus.start_i = 1'b1;
    bus.a_i = $urandom;
    bus.b_i = $urandom;
    @(negedge clk_i);
    bus.a_i = $urandom;
    bus.b_i = $urandom;
    @(negedge clk_i);
    chk("reset busy", 64'(bus.busy_o), 64'd0);
    chk("reset valid", 64'(bus.valid_o), 64'd0);
    chk("reset result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("no start after reset", 64'(bus.busy_o), 64'd0);

    // Table-driven products
    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, res);
      if (i == 3) chk("reduced 0x80000000*2", res % RED_M, 64'd2);
      if (i == 4) chk("reduced 0x7FFFFFFF*0x12345", res % RED_M, 64'd0);
    end

    // Start during CALC is ignored, operand changes after acceptance have
    // no effect; start held high restarts at k+34.
    @(negedge clk_i);
    bus.a_i = 32'd6;
    bus.b_i = 32'd7;
    bus.start_i = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    bus.a_i = 32'd9;
    bus.b_i = 32'd9;
    vcnt = 0;
    vlat = -1;
    vres = '0;
    b33 = 1'b1;
    b34 = 1'b0;
    r34 = '0;
    for (int lat = 0; lat <= 34; lat++) begin
      if (lat == 5) bus.start_i = 1'b1;
      if (lat == 7) bus.start_i = 1'b0;
      if (lat == 20) bus.start_i = 1'b1;
      if (bus.valid_o) begin
        vcnt++;
        vlat = lat;
        vres = bus.result_o;
      end
      if (lat == 33) b33 = bus.busy_o;
      if (lat == 34) begin
        b34 = bus.busy_o;
        r34 = bus.result_o;
      end
      if (lat < 34) @(negedge clk_i);
    end
    bus.start_i = 1'b0;
    chk("ignored start valid count", 64'(vcnt), 64'd1);
    chk("ignored start latency", 64'(vlat), 64'(W));
    chk("ignored start product", vres, 64'd42);
    chk("idle before re-accept", 64'(b33), 64'd0);
    chk("re-accept at k+34", 64'(b34), 64'd1);
    chk("result held on accept", r34, 64'd42);
    vlat = 0;
    while (!bus.valid_o && vlat < 100) begin
      @(negedge clk_i);
      vlat++;
    end
    chk("restart product 9*9", bus.result_o, 64'd81);
    @(negedge clk_i);
    @(negedge clk_i);

    // Abort by reset at the 10th CALC cycle
    bus.a_i = 32'd100;
    bus.b_i = 32'd100;
    bus.start_i = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("abort result cleared", bus.result_o, 64'd0);
    chk("abort busy cleared", 64'(bus.busy_o), 64'd0);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.valid_o) vcnt++;
      @(negedge clk_i);
    end
    chk("abort no valid", 64'(vcnt), 64'd0);
    chk("abort result stays 0", bus.result_o, 64'd0);
    do_op("after abort 7*6", 32'd7, 32'd6, 64'd42, res);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
